step_control_decoder: RTL and testbench

Consumer end of the control-step interface. Samples the 1..5 step count produced by the clock counter, latches the instruction opcode, and drives the datapath control signals for each step. Stalls the counter through `Hold` while a memory access awaits memory-function-complete (`MFC`). Also checks that the incoming step sequence is legal.

---
 rtl/control_pkg.sv | 56 +++++
 rtl/step_seq_checker.sv | 42 ++++
 rtl/step_control_decoder.sv | 147 ++++++++++++++
 tb/tb_step_control_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the control-step decoder: opcodes, ALU/writeback selects, FSM states, step numbers.
package control_pkg;

  localparam logic [2:0] STEP_FETCH  = 3'd1;
  localparam logic [2:0] STEP_DECODE = 3'd2;
  localparam logic [2:0] STEP_EXEC   = 3'd3;
  localparam logic [2:0] STEP_MEM    = 3'd4;
  localparam logic [2:0] STEP_WB     = 3'd5;

  localparam logic [31:0] OP_ADD    = 32'd1;
  localparam logic [31:0] OP_SUB    = 32'd2;
  localparam logic [31:0] OP_AND    = 32'd3;
  localparam logic [31:0] OP_OR     = 32'd4;
  localparam logic [31:0] OP_LOAD   = 32'd5;
  localparam logic [31:0] OP_STORE  = 32'd6;
  localparam logic [31:0] OP_ADDI   = 32'd7;
  localparam logic [31:0] OP_BRANCH = 32'd8;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam logic [1:0] YSEL_ALU = 2'd0;
  localparam logic [1:0] YSEL_MEM = 2'd1;
  localparam logic [1:0] YSEL_RET = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_MEMWAIT, ST_FAULT} state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_ADDI, CLS_BRANCH
  } op_class_e;

  function automatic op_class_e op_class(input logic [31:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_ALU;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_ADDI:   op_class = CLS_ADDI;
      OP_BRANCH: op_class = CLS_BRANCH;
      default:   op_class = CLS_NOP;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] op);
    case (op)
      OP_ADD:  alu_of = ALU_ADD;
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/step_seq_checker.sv
// Tracks the previous step count and flags any transition the clock counter should never make.
module step_seq_checker
  import control_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [2:0] count,
  input  logic       hold,
  output logic [2:0] prev_count,
  output logic       illegal
);

  logic prev_hold;
  logic legal;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      prev_count <= 3'd0;
      prev_hold  <= 1'b0;
    end else begin
      prev_count <= count;
      prev_hold  <= hold;
    end
  end

  // A repeated step is only legal if we asked the counter to stall on the previous cycle.
  always_comb begin
    legal = 1'b0;
    case (prev_count)
      3'd0:                  legal = (count == 3'd0) || (count == STEP_FETCH);
      3'd1, 3'd2, 3'd3, 3'd4: legal = (count == prev_count + 3'd1) ||
                                      ((count == prev_count) && prev_hold);
      3'd5:                  legal = (count == STEP_FETCH) ||
                                     ((count == STEP_WB) && prev_hold);
      default:               legal = 1'b0;
    endcase
  end

  // Masked during reset so the flag cannot flash while the counter input is undefined.
  assign illegal = Resetn && !legal;

endmodule

// File: rtl/step_control_decoder.sv
// Decodes the 1..5 control step and latched opcode into datapath controls, stalls the
// counter on memory accesses until MFC, and latches a fault on an illegal step sequence.
module step_control_decoder
  import control_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [2:0]     ClockCount,
  input  logic [OPW-1:0] Opcode,
  input  logic           MFC,
  output logic           Hold,
  output logic           PCEnable,
  output logic           PCSel,
  output logic           IREnable,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RFWrite,
  output logic [2:0]     ALUOp,
  output logic [1:0]     YSel,
  output logic           SeqError
);

  state_e         state, state_nxt;
  logic [OPW-1:0] opcode_q;
  logic [2:0]     prev_count;
  logic           illegal;
  op_class_e      cls;
  logic [2:0]     alu_code;
  logic           active;
  logic           mem_req;

  step_seq_checker u_chk (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .count      (ClockCount),
    .hold       (Hold),
    .prev_count (prev_count),
    .illegal    (illegal)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Capture only on entry to step 2 so a stall there cannot pick up a changed IR.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      opcode_q <= '0;
    else if (state != ST_FAULT && ClockCount == STEP_DECODE && prev_count != STEP_DECODE)
      opcode_q <= Opcode;
  end

  assign cls      = op_class(32'(opcode_q));
  assign alu_code = alu_of(32'(opcode_q));
  assign active   = (state == ST_RUN) || (state == ST_MEMWAIT);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    Hold      = 1'b0;
    PCEnable  = 1'b0;
    PCSel     = 1'b0;
    IREnable  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RFWrite   = 1'b0;
    ALUOp     = ALU_PASS;
    YSel      = YSEL_ALU;

    if (active) begin
      case (ClockCount)
        STEP_FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (MFC) begin
            IREnable = 1'b1;
            PCEnable = 1'b1;
          end
        end
        STEP_EXEC: begin
          case (cls)
            CLS_ALU:                      ALUOp = alu_code;
            CLS_ADDI, CLS_LOAD, CLS_STORE: ALUOp = ALU_ADD;
            CLS_BRANCH: begin
              PCEnable = 1'b1;
              PCSel    = 1'b1;
            end
            default: ;
          endcase
        end
        STEP_MEM: begin
          if (cls == CLS_LOAD) begin
            mem_req = 1'b1;
            MemRead = 1'b1;
          end else if (cls == CLS_STORE) begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
          end
        end
        STEP_WB: begin
          case (cls)
            CLS_ALU, CLS_ADDI: RFWrite = 1'b1;
            CLS_LOAD: begin
              RFWrite = 1'b1;
              YSel    = YSEL_MEM;
            end
            CLS_BRANCH: begin
              RFWrite = 1'b1;
              YSel    = YSEL_RET;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // The request cycle itself stalls too, which is what makes an access last k+1 cycles.
    Hold = mem_req && !MFC;

    case (state)
      ST_IDLE:    if (ClockCount == STEP_FETCH) state_nxt = ST_RUN;
      ST_RUN:     if (mem_req && !MFC) state_nxt = ST_MEMWAIT;
      ST_MEMWAIT: if (mem_req && MFC) state_nxt = ST_RUN;
      default:    state_nxt = ST_FAULT;
    endcase

    if (illegal) begin
      state_nxt = ST_FAULT;
      Hold      = 1'b0;
      PCEnable  = 1'b0;
      PCSel     = 1'b0;
      IREnable  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RFWrite   = 1'b0;
      ALUOp     = ALU_PASS;
      YSel      = YSEL_ALU;
    end
  end

  assign SeqError = (state == ST_FAULT) || illegal;

endmodule

// File: tb/tb_step_control_decoder.sv
// Table-driven bench for step_control_decoder with an expected-value queue and reset corner cases.
module tb_step_control_decoder;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [2:0] ClockCount;
  logic [3:0] Opcode;
  logic       MFC;
  logic       Hold, PCEnable, PCSel, IREnable, MemRead, MemWrite, RFWrite, SeqError;
  logic [2:0] ALUOp;
  logic [1:0] YSel;

  step_control_decoder #(.OPW(4)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .ClockCount (ClockCount),
    .Opcode     (Opcode),
    .MFC        (MFC),
    .Hold       (Hold),
    .PCEnable   (PCEnable),
    .PCSel      (PCSel),
    .IREnable   (IREnable),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RFWrite    (RFWrite),
    .ALUOp      (ALUOp),
    .YSel       (YSel),
    .SeqError   (SeqError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  count;
    logic [3:0]  op;
    logic        mfc;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  vec_t        tbl2[$];
  logic [12:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  // {Hold,PCEnable,PCSel,IREnable,MemRead,MemWrite,RFWrite,ALUOp,YSel,SeqError}
  function automatic logic [12:0] mk(input logic h, pce, pcs, ire, mr, mw, rfw,
                                     input logic [2:0] alu, input logic [1:0] ys,
                                     input logic err);
    return {h, pce, pcs, ire, mr, mw, rfw, alu, ys, err};
  endfunction

  function automatic logic [12:0] outs();
    return {Hold, PCEnable, PCSel, IREnable, MemRead, MemWrite, RFWrite, ALUOp, YSel, SeqError};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (H,PCE,PCS,IRE,MR,MW,RFW,ALU,YS,ERR)", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge Clock);
    #1;
    ClockCount = v.count;
    Opcode     = v.op;
    MFC        = v.mfc;
    sb.push_back(v.exp);
    @(negedge Clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", v.name, outs());
    end else begin
      check(v.name, outs(), sb.pop_front());
    end
  endtask

  function automatic vec_t V(input logic [2:0] c, input logic [3:0] op, input logic mfc,
                             input logic [12:0] e, input string n);
    vec_t v;
    v.count = c; v.op = op; v.mfc = mfc; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    logic [12:0] z, fetch, err;
    z     = mk(0,0,0,0,0,0,0,3'd0,2'd0,0);
    fetch = mk(0,1,0,1,1,0,0,3'd0,2'd0,0);
    err   = mk(0,0,0,0,0,0,0,3'd0,2'd0,1);

    // Warm-up instruction: the first step 1 is seen in IDLE and produces nothing.
    tbl.push_back(V(3'd0, 4'd0, 0, z, "idle_cnt0"));
    tbl.push_back(V(3'd1, 4'd0, 1, z, "idle_step1"));
    tbl.push_back(V(3'd2, 4'd0, 0, z, "nop_s2"));
    tbl.push_back(V(3'd3, 4'd0, 0, z, "nop_s3"));
    tbl.push_back(V(3'd4, 4'd0, 1, z, "nop_s4_mfc_ignored"));
    tbl.push_back(V(3'd5, 4'd0, 0, z, "nop_s5"));
    // ADD
    tbl.push_back(V(3'd1, 4'd1, 1, fetch, "add_s1"));
    tbl.push_back(V(3'd2, 4'd1, 0, z, "add_s2"));
    tbl.push_back(V(3'd3, 4'd1, 0, mk(0,0,0,0,0,0,0,3'd1,2'd0,0), "add_s3"));
    tbl.push_back(V(3'd4, 4'd1, 0, z, "add_s4"));
    tbl.push_back(V(3'd5, 4'd1, 0, mk(0,0,0,0,0,0,1,3'd0,2'd0,0), "add_s5"));
    // LOAD with MFC three cycles after the step-4 request
    tbl.push_back(V(3'd1, 4'd5, 1, fetch, "ld_s1"));
    tbl.push_back(V(3'd2, 4'd5, 0, z, "ld_s2"));
    tbl.push_back(V(3'd3, 4'd5, 0, mk(0,0,0,0,0,0,0,3'd1,2'd0,0), "ld_s3"));
    tbl.push_back(V(3'd4, 4'd5, 0, mk(1,0,0,0,1,0,0,3'd0,2'd0,0), "ld_s4_w0"));
    tbl.push_back(V(3'd4, 4'd5, 0, mk(1,0,0,0,1,0,0,3'd0,2'd0,0), "ld_s4_w1"));
    tbl.push_back(V(3'd4, 4'd5, 0, mk(1,0,0,0,1,0,0,3'd0,2'd0,0), "ld_s4_w2"));
    tbl.push_back(V(3'd4, 4'd5, 1, mk(0,0,0,0,1,0,0,3'd0,2'd0,0), "ld_s4_mfc"));
    tbl.push_back(V(3'd5, 4'd5, 0, mk(0,0,0,0,0,0,1,3'd0,2'd1,0), "ld_s5"));
    // BRANCH with a one-cycle fetch stall
    tbl.push_back(V(3'd1, 4'd8, 0, mk(1,0,0,0,1,0,0,3'd0,2'd0,0), "br_s1_wait"));
    tbl.push_back(V(3'd1, 4'd8, 1, fetch, "br_s1_mfc"));
    tbl.push_back(V(3'd2, 4'd8, 0, z, "br_s2"));
    tbl.push_back(V(3'd3, 4'd8, 0, mk(0,1,1,0,0,0,0,3'd0,2'd0,0), "br_s3"));
    tbl.push_back(V(3'd4, 4'd8, 0, z, "br_s4"));
    tbl.push_back(V(3'd5, 4'd8, 0, mk(0,0,0,0,0,0,1,3'd0,2'd2,0), "br_s5"));
    // STORE, IR changes after the latch, MFC in the request cycle
    tbl.push_back(V(3'd1, 4'd6, 1, fetch, "st_s1"));
    tbl.push_back(V(3'd2, 4'd6, 0, z, "st_s2"));
    tbl.push_back(V(3'd3, 4'd1, 0, mk(0,0,0,0,0,0,0,3'd1,2'd0,0), "st_s3"));
    tbl.push_back(V(3'd4, 4'd1, 1, mk(0,0,0,0,0,1,0,3'd0,2'd0,0), "st_s4_nostall"));
    tbl.push_back(V(3'd5, 4'd1, 0, z, "st_s5"));
    // ADDI
    tbl.push_back(V(3'd1, 4'd7, 1, fetch, "addi_s1"));
    tbl.push_back(V(3'd2, 4'd7, 0, z, "addi_s2"));
    tbl.push_back(V(3'd3, 4'd7, 0, mk(0,0,0,0,0,0,0,3'd1,2'd0,0), "addi_s3"));
    tbl.push_back(V(3'd4, 4'd7, 0, z, "addi_s4"));
    tbl.push_back(V(3'd5, 4'd7, 0, mk(0,0,0,0,0,0,1,3'd0,2'd0,0), "addi_s5"));
    // OR
    tbl.push_back(V(3'd1, 4'd4, 1, fetch, "or_s1"));
    tbl.push_back(V(3'd2, 4'd4, 0, z, "or_s2"));
    tbl.push_back(V(3'd3, 4'd4, 0, mk(0,0,0,0,0,0,0,3'd4,2'd0,0), "or_s3"));
    tbl.push_back(V(3'd4, 4'd4, 0, z, "or_s4"));
    tbl.push_back(V(3'd5, 4'd4, 0, mk(0,0,0,0,0,0,1,3'd0,2'd0,0), "or_s5"));
    // Illegal 2->4 skip, then fault persists
    tbl.push_back(V(3'd1, 4'd1, 1, fetch, "bad_s1"));
    tbl.push_back(V(3'd2, 4'd1, 0, z, "bad_s2"));
    tbl.push_back(V(3'd4, 4'd1, 0, err, "bad_skip4"));
    tbl.push_back(V(3'd5, 4'd1, 0, err, "fault_s5"));
    tbl.push_back(V(3'd1, 4'd1, 1, err, "fault_s1"));

    // After reset: warm-up, then a STORE stalled at step 4
    tbl2.push_back(V(3'd0, 4'd0, 0, z, "r2_cnt0"));
    tbl2.push_back(V(3'd1, 4'd0, 0, z, "r2_idle_s1"));
    tbl2.push_back(V(3'd2, 4'd0, 0, z, "r2_s2"));
    tbl2.push_back(V(3'd3, 4'd0, 0, z, "r2_s3"));
    tbl2.push_back(V(3'd4, 4'd0, 0, z, "r2_s4"));
    tbl2.push_back(V(3'd5, 4'd0, 0, z, "r2_s5"));
    tbl2.push_back(V(3'd1, 4'd6, 1, fetch, "r2_st_s1"));
    tbl2.push_back(V(3'd2, 4'd6, 0, z, "r2_st_s2"));
    tbl2.push_back(V(3'd3, 4'd6, 0, mk(0,0,0,0,0,0,0,3'd1,2'd0,0), "r2_st_s3"));
    tbl2.push_back(V(3'd4, 4'd6, 0, mk(1,0,0,0,0,1,0,3'd0,2'd0,0), "r2_st_w0"));
    tbl2.push_back(V(3'd4, 4'd6, 0, mk(1,0,0,0,0,1,0,3'd0,2'd0,0), "r2_st_w1"));

    // Reset with a nonzero step on the input
    Resetn = 1'b0; ClockCount = 3'd3; Opcode = 4'd5; MFC = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_state", outs(), z);
    ClockCount = 3'd0;
    Resetn = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset pulse clears the fault
    @(posedge Clock); #1;
    Resetn = 1'b0; ClockCount = 3'd0; MFC = 1'b0;
    #1 check("reset_clears_fault", outs(), z);
    @(negedge Clock);
    Resetn = 1'b1;

    foreach (tbl2[i]) apply(tbl2[i]);

    // Asynchronous reset in the middle of the store stall
    @(posedge Clock); #1;
    Resetn = 1'b0;
    #1 check("reset_mid_stall", outs(), z);
    ClockCount = 3'd0;
    @(negedge Clock);
    Resetn = 1'b1;
    apply(V(3'd0, 4'd0, 0, z, "post_rst_cnt0"));
    apply(V(3'd1, 4'd0, 1, z, "post_rst_idle_s1"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
